// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative MULTU/DIVU unit with HI/LO registers.
// Ports: clk, reset (async, active-low), start/op/a/b request in,
//   busy/done status, hi/lo result flops, dz divide-by-zero flag.
//   op: 00 MULTU, 01 DIVU, 10 MTHI, 11 MTLO.
//   DIVU, the DIV state and dz exist only with MDU_DIV_EN defined;
//   otherwise op=01 is a no-op and dz is tied low.
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
`ifdef MDU_DIV_EN
        DIV,
`endif
        DONE
    } state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               accept;

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   sub;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
`endif

    assign busy   = (state_q == MUL)
`ifdef MDU_DIV_EN
                  | (state_q == DIV)
`endif
                  ;
    assign done   = (state_q == DONE);
    assign accept = start & ~busy;
    assign hi     = hi_q;
    assign lo     = lo_q;

    // Shift-add: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the pair right.
    always_comb begin
        msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]};
        if (prod_q[0]) begin
            msum = msum + {1'b0, mcand_q};
        end
        prod_nxt = {msum, prod_q[WIDTH-1:1]};
    end

`ifdef MDU_DIV_EN
    assign dz = dz_q;

    // Restoring step on a WIDTH+1 bit trial remainder. The low
    // WIDTH bits are subtracted; a set trial MSB means the trial
    // already exceeds any divisor, so the low difference is exact.
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]};
        sub     = {1'b0, trial[WIDTH-1:0]} - {1'b0, dvs_q};
        ge      = trial[WIDTH] | ~sub[WIDTH];
        rem_nxt = ge ? sub[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nxt = {quo_q[WIDTH-2:0], ge};
    end
`else
    assign dz = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
`ifdef MDU_DIV_EN
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dz_d    = dz_q;
`endif

        case (state_q)
            MUL: begin
                prod_d = prod_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = prod_nxt[2*WIDTH-1:WIDTH];
                    lo_d    = prod_nxt[WIDTH-1:0];
                    state_d = DONE;
                end
            end
`ifdef MDU_DIV_EN
            DIV: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = rem_nxt;
                    lo_d    = quo_nxt;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase

        // Only reachable from IDLE or DONE; overrides DONE -> IDLE.
        if (accept) begin
            case (op)
                2'b00: begin
                    mcand_d = a;
                    prod_d  = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = MUL;
`ifdef MDU_DIV_EN
                    dz_d    = 1'b0;
`endif
                end
`ifdef MDU_DIV_EN
                2'b01: begin
                    if (b == '0) begin
                        hi_d    = a;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a;
                        dvs_d   = b;
                        cnt_d   = '0;
                        dz_d    = 1'b0;
                        state_d = DIV;
                    end
                end
`endif
                2'b10: begin
                    hi_d    = a;
                    state_d = IDLE;
                end
                2'b11: begin
                    lo_d    = a;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
`ifdef MDU_DIV_EN
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
`ifdef MDU_DIV_EN
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dz_q    <= dz_d;
`endif
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed vector bench for hilo_mdu (WIDTH=32).
// Table of ops with expected hi/lo/dz, busy cycles and done.
module tb_hilo_mdu;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;

    int checks;
    int errors;

    hilo_mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start_i),
        .op    (op_i),
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          nb;
        logic        dn;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] h,
        input logic [31:0] l,
        input logic        z,
        input int          nb,
        input logic        dn
    );
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.hi = h; v.lo = l; v.dz = z;
        v.nb = nb; v.dn = dn;
        return v;
    endfunction

    task automatic chk(
        input string       nm,
        input logic [63:0] act,
        input logic [63:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Issue one op, then follow it until done or idle.
    task automatic run_vec(input int idx, input vec_t v);
        int nb;
        int i;
        logic got;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        start_i = 1'b1; op_i = v.op; a_i = v.a; b_i = v.b;
        @(negedge clk);
        start_i = 1'b0;
        nb = 0; got = 1'b0; i = 0;
        while (i < 40) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!busy) break;
            nb++;
            @(negedge clk);
            i++;
        end
        chk({tag, "_busy"}, 64'(nb), 64'(v.nb));
        chk({tag, "_done"}, 64'(got), 64'(v.dn));
        chk({tag, "_hi"}, 64'(hi), 64'(v.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(v.lo));
        chk({tag, "_dz"}, 64'(dz), 64'(v.dz));
    endtask

    initial begin
        int nb;
        int nd;
        logic got;
        checks = 0; errors = 0;
        rst_n = 1'b0; start_i = 1'b0;
        op_i = 2'b00; a_i = '0; b_i = '0;

        vq.push_back(mk(2'b11, 32'h1234, 0,
                        32'h0, 32'h1234, 0, 0, 0));
        vq.push_back(mk(2'b10, 32'hABCD, 0,
                        32'hABCD, 32'h1234, 0, 0, 0));
        vq.push_back(mk(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                        32'hFFFFFFFE, 32'h00000001, 0, 32, 1));
        vq.push_back(mk(2'b00, 3, 4, 0, 12, 0, 32, 1));
        vq.push_back(mk(2'b00, 32'h10000, 32'h10000,
                        1, 0, 0, 32, 1));
        vq.push_back(mk(2'b00, 32'h12345678, 0,
                        0, 0, 0, 32, 1));
        vq.push_back(mk(2'b00, 32'h80000000, 2,
                        1, 0, 0, 32, 1));
        vq.push_back(mk(2'b00, 32'hFFFFFFFF, 32'h80000000,
                        32'h7FFFFFFF, 32'h80000000, 0, 32, 1));
        vq.push_back(mk(2'b00, 32'hDEADBEEF, 1,
                        0, 32'hDEADBEEF, 0, 32, 1));
        vq.push_back(mk(2'b00, 32'hFFFF, 32'hFFFF,
                        0, 32'hFFFE0001, 0, 32, 1));
`ifdef MDU_DIV_EN
        vq.push_back(mk(2'b01, 100, 7, 2, 14, 0, 32, 1));
        vq.push_back(mk(2'b01, 32'hFFFFFFFF, 32'h80000000,
                        32'h7FFFFFFF, 1, 0, 32, 1));
        vq.push_back(mk(2'b01, 7, 100, 7, 0, 0, 32, 1));
        vq.push_back(mk(2'b01, 32'hFFFFFFFF, 1,
                        0, 32'hFFFFFFFF, 0, 32, 1));
        vq.push_back(mk(2'b01, 5, 0,
                        5, 32'hFFFFFFFF, 1, 0, 1));
        vq.push_back(mk(2'b11, 32'h42, 0,
                        5, 32'h42, 1, 0, 0));
        vq.push_back(mk(2'b00, 2, 3, 0, 6, 0, 32, 1));
`else
        vq.push_back(mk(2'b01, 32'h77, 3,
                        0, 32'hFFFE0001, 0, 0, 0));
        vq.push_back(mk(2'b10, 32'h99, 0,
                        32'h99, 32'hFFFE0001, 0, 0, 0));
`endif

        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_dz", 64'(dz), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(i, vq[i]);
        end

        // Start while busy must be ignored.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; a_i = 3; b_i = 4;
        @(negedge clk);
        nb = 0; nd = 0;
        for (int i = 0; i < 45; i++) begin
            if (busy) nb++;
            if (done) nd++;
            if (i == 4) begin
                start_i = 1'b1; a_i = 9; b_i = 9;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_busy", 64'(nb), 64'd32);
        chk("ign_done", 64'(nd), 64'd1);
        chk("ign_hi", 64'(hi), 64'h0);
        chk("ign_lo", 64'(lo), 64'd12);

        // Reset in the middle of a multiply.
        start_i = 1'b1; op_i = 2'b00;
        a_i = 32'h10000; b_i = 32'h10000;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        chk("mid_busy_pre", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_hi", 64'(hi), 64'h0);
        chk("mid_lo", 64'(lo), 64'h0);
        chk("mid_busy", 64'(busy), 64'h0);
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mid_nodone", 64'(nd), 64'h0);
        run_vec(100, mk(2'b00, 2, 3, 0, 6, 0, 32, 1));

        // New start accepted straight out of DONE.
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; a_i = 7; b_i = 8;
        @(negedge clk);
        start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else @(negedge clk);
        end
        chk("b2b_first", 64'(lo), 64'd56);
        start_i = 1'b1; a_i = 5; b_i = 6;
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b_busy", 64'(busy), 64'h1);
        nb = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) got = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        chk("b2b_cycles", 64'(nb), 64'd32);
        chk("b2b_lo", 64'(lo), 64'd30);
        start_i = 1'b1; op_i = 2'b10; a_i = 32'h55;
        @(negedge clk);
        start_i = 1'b0;
        chk("dmth_hi", 64'(hi), 64'h55);
        chk("dmth_lo", 64'(lo), 64'd30);
        chk("dmth_busy", 64'(busy), 64'h0);
        chk("dmth_done", 64'(done), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
